// File: rtl/mm_ternary_stream_acc.sv
// -----------------------------------------------------------------------------
// mm_ternary_stream_acc
//
// Streaming ternary GEMM engine. A ROW_NUM x COL_NUM grid of ternary
// dot-product cells accumulates the K dimension over one or more LENGTH-wide
// beats. When a tile closes, the finished tile is copied into a result buffer
// and offered downstream through a valid/ready handshake.
//
// Weight code: 2'b01 = +1, 2'b11 = -1, 2'b00 / 2'b10 = 0 (add / sub / skip).
//
// Ports
//   clk        in   clock, all state on posedge
//   reset      in   synchronous, active-high
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid & in_ready
//   in_last    in   beat is the last of the current tile
//   mat        in   activations, row i elem k at element (i*LENGTH+k)
//   fil        in   2-bit ternary weights, elem (k,j) at element (k*COL_NUM+j)
//   out_valid  out  result tile valid
//   out_ready  in   downstream accepts tile
//   res        out  results, cell (i,j) at element (i*COL_NUM+j)
//   err_ovf    out  sticky: a tile was force-closed at MAX_BEATS
//
// Configuration macro
//   MM_TERNARY_SAT_EN  defined: results saturate to the signed OUT_WIDTH range
//                      undefined: results keep the low OUT_WIDTH bits (wrap)
// -----------------------------------------------------------------------------
module mm_ternary_stream_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 4,
  parameter int COL_NUM    = 4,
  parameter int LENGTH     = 8,
  parameter int MAX_BEATS  = 16,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_last,
  input  logic [DATA_WIDTH*ROW_NUM*LENGTH-1:0] mat,
  input  logic [2*LENGTH*COL_NUM-1:0]          fil,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_WIDTH*ROW_NUM*COL_NUM-1:0] res,
  output logic                                 err_ovf
);

  // Wide enough for MAX_BEATS full-scale beats, so accumulation never overflows.
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(LENGTH*MAX_BEATS) + 1;
  localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1);
  localparam int CELLS     = ROW_NUM * COL_NUM;

  typedef enum logic {
    IDLE,   // no partial tile held
    ACCUM   // partial tile held in the accumulators
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        beat_cnt_q, beat_cnt_d, beat_cnt_inc;
  logic signed [ACC_WIDTH-1:0] acc_q [CELLS];
  logic signed [ACC_WIDTH-1:0] acc_d [CELLS];
  logic signed [ACC_WIDTH-1:0] dot   [CELLS];
  logic [OUT_WIDTH*CELLS-1:0]  res_q, res_d;
  logic                        out_valid_q, out_valid_d;
  logic                        err_q, err_d;
  logic                        beat_fire, tile_close;

`ifdef MM_TERNARY_SAT_EN
  // One spare bit above the wider of the two widths keeps the compare exact.
  localparam int EXT_WIDTH = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;
  localparam logic signed [EXT_WIDTH-1:0] OUT_MAX =
    {{(EXT_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  function automatic logic [OUT_WIDTH-1:0] to_out(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [EXT_WIDTH-1:0] ext;
    ext = EXT_WIDTH'(a);
    if (ext > OUT_MAX)      return OUT_MAX[OUT_WIDTH-1:0];
    else if (ext < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    else                    return ext[OUT_WIDTH-1:0];
  endfunction
`else
  // Signed size cast: truncates to the low bits (wrap) or sign-extends.
  function automatic logic [OUT_WIDTH-1:0] to_out(input logic signed [ACC_WIDTH-1:0] a);
    return OUT_WIDTH'(a);
  endfunction
`endif

  // Per-cell ternary dot product of the current beat.
  always_comb begin : dot_calc
    logic signed [DATA_WIDTH-1:0] elem;
    logic [1:0]                   code;
    elem = '0;
    code = '0;
    for (int i = 0; i < ROW_NUM; i++) begin
      for (int j = 0; j < COL_NUM; j++) begin
        dot[i*COL_NUM+j] = '0;
        for (int k = 0; k < LENGTH; k++) begin
          elem = mat[(i*LENGTH+k)*DATA_WIDTH +: DATA_WIDTH];
          code = fil[(k*COL_NUM+j)*2 +: 2];
          case (code)
            2'b01:   dot[i*COL_NUM+j] = dot[i*COL_NUM+j] + ACC_WIDTH'(elem);
            2'b11:   dot[i*COL_NUM+j] = dot[i*COL_NUM+j] - ACC_WIDTH'(elem);
            default: ;
          endcase
        end
      end
    end
  end

  // A full buffer that is not draining stalls every beat, last or not.
  assign in_ready  = !out_valid_q || out_ready;
  assign beat_fire = in_valid && in_ready;

  // Beat number the accepted beat would carry; 1 when starting from IDLE.
  assign beat_cnt_inc = (state_q == IDLE) ? CNT_WIDTH'(1) : beat_cnt_q + CNT_WIDTH'(1);
  assign tile_close   = beat_fire && (in_last || (beat_cnt_inc == CNT_WIDTH'(MAX_BEATS)));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (beat_fire) begin
      // First beat of a tile overwrites, so stale sums never leak in.
      for (int c = 0; c < CELLS; c++) begin
        acc_d[c] = (state_q == IDLE) ? dot[c] : acc_q[c] + dot[c];
      end
      beat_cnt_d = beat_cnt_inc;
      state_d    = ACCUM;
    end

    // A close in the same cycle as a transfer keeps out_valid high with new data.
    if (tile_close) begin
      for (int c = 0; c < CELLS; c++) begin
        res_d[c*OUT_WIDTH +: OUT_WIDTH] = to_out(acc_d[c]);
      end
      out_valid_d = 1'b1;
      state_d     = IDLE;
      beat_cnt_d  = '0;
      if (!in_last) err_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      // NOTE: the accumulator array is reset explicitly; it is a small flop
      // array, not a RAM, and a defined post-reset value is required.
      for (int c = 0; c < CELLS; c++) acc_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign err_ovf   = err_q;

endmodule

// File: tb/tb_mm_ternary_stream_acc.sv
// -----------------------------------------------------------------------------
// tb_mm_ternary_stream_acc
//
// Drives two instances from one stimulus stream: dut_a with default
// parameters and dut_b with OUT_WIDTH=8, MAX_BEATS=4 (narrow output, early
// forced close). Each instance is tracked by its own cycle-level reference
// model built from integer arithmetic. Directed tiles are followed by a
// randomized phase with random gaps, backpressure and resets.
// -----------------------------------------------------------------------------
module tb_mm_ternary_stream_acc;

  localparam int DW = 8;
  localparam int RN = 4;
  localparam int CN = 4;
  localparam int LN = 8;
  localparam int CELLS = RN * CN;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_last;
  logic                  out_ready;
  logic [DW*RN*LN-1:0]   mat;
  logic [2*LN*CN-1:0]    fil;

  logic                  in_ready_a, out_valid_a, err_a;
  logic [16*CELLS-1:0]   res_a;
  logic                  in_ready_b, out_valid_b, err_b;
  logic [8*CELLS-1:0]    res_b;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int m_ow [2] = '{16, 8};
  int m_mb [2] = '{16, 4};
  int m_sum   [2][CELLS];
  int m_res   [2][CELLS];
  int m_beats [2];
  bit m_open  [2];
  bit m_ov    [2];
  bit m_err   [2];

  mm_ternary_stream_acc dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_last   (in_last),
    .mat       (mat),
    .fil       (fil),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .res       (res_a),
    .err_ovf   (err_a)
  );

  mm_ternary_stream_acc #(.OUT_WIDTH(8), .MAX_BEATS(4)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_last   (in_last),
    .mat       (mat),
    .fil       (fil),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .res       (res_b),
    .err_ovf   (err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Ternary dot product of the current beat for cell (i,j).
  function automatic int dot_of(input int i, input int j);
    int s = 0;
    for (int k = 0; k < LN; k++) begin
      logic signed [DW-1:0] a;
      logic [1:0]           code;
      int                   w;
      a    = mat[(i*LN+k)*DW +: DW];
      code = fil[(k*CN+j)*2 +: 2];
      w    = (code == 2'b01) ? 1 : (code == 2'b11) ? -1 : 0;
      s   += w * int'(a);
    end
    return s;
  endfunction

  function automatic int conv(input int s, input int w);
    int lim = 1 << (w - 1);
`ifdef MM_TERNARY_SAT_EN
    if (s > lim - 1) return lim - 1;
    if (s < -lim)    return -lim;
    return s;
`else
    int m = s & ((1 << w) - 1);
    if (m >= lim) m -= (1 << w);
    return m;
`endif
  endfunction

  task automatic model_update(input int d);
    bit nov;
    if (reset) begin
      for (int c = 0; c < CELLS; c++) begin
        m_sum[d][c] = 0;
        m_res[d][c] = 0;
      end
      m_beats[d] = 0;
      m_open[d]  = 0;
      m_ov[d]    = 0;
      m_err[d]   = 0;
      return;
    end
    nov = m_ov[d] && !out_ready;
    if (in_valid && (!m_ov[d] || out_ready)) begin
      m_beats[d] = m_open[d] ? m_beats[d] + 1 : 1;
      for (int c = 0; c < CELLS; c++) begin
        m_sum[d][c] = (m_open[d] ? m_sum[d][c] : 0) + dot_of(c / CN, c % CN);
      end
      m_open[d] = 1;
      if (in_last || m_beats[d] == m_mb[d]) begin
        for (int c = 0; c < CELLS; c++) m_res[d][c] = conv(m_sum[d][c], m_ow[d]);
        nov       = 1;
        m_open[d] = 0;
        if (!in_last) m_err[d] = 1;
      end
    end
    m_ov[d] = nov;
  endtask

  task automatic compare(input int d);
    logic [255:0] ev;
    ev = '0;
    for (int c = 0; c < CELLS; c++) begin
      for (int b = 0; b < m_ow[d]; b++) ev[c*m_ow[d] + b] = m_res[d][c][b];
    end
    if (d == 0) begin
      check("in_ready_a",  256'(in_ready_a),  256'(!m_ov[0] || out_ready));
      check("out_valid_a", 256'(out_valid_a), 256'(m_ov[0]));
      check("err_ovf_a",   256'(err_a),       256'(m_err[0]));
      check("res_a",       256'(res_a),       ev);
    end else begin
      check("in_ready_b",  256'(in_ready_b),  256'(!m_ov[1] || out_ready));
      check("out_valid_b", 256'(out_valid_b), 256'(m_ov[1]));
      check("err_ovf_b",   256'(err_b),       256'(m_err[1]));
      check("res_b",       256'(res_b),       ev);
    end
  endtask

  // One clock: compare current outputs, clock the DUTs and the model.
  task automatic step();
    #1;
    if (chk_en) begin
      compare(0);
      compare(1);
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
  endtask

  task automatic set_beat(input int v, input logic [1:0] code, input bit last);
    for (int e = 0; e < RN*LN; e++) mat[e*DW +: DW] = DW'(v);
    for (int e = 0; e < LN*CN; e++) fil[e*2 +: 2] = code;
    in_valid = 1'b1;
    in_last  = last;
  endtask

  task automatic beat(input int v, input logic [1:0] code, input bit last);
    set_beat(v, code, last);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    mat       = '0;
    fil       = '0;

    // Reset state
    step();
    step();
    #1;
    check("rst_out_valid", 256'(out_valid_a), 256'(0));
    check("rst_in_ready",  256'(in_ready_a),  256'(1));
    check("rst_err",       256'(err_a),       256'(0));
    check("rst_res",       256'(res_a),       256'(0));
    reset  = 1'b0;
    chk_en = 1;
    idle(1);

    // Single beat: 8 x 3 x (+1) = 24
    beat(3, 2'b01, 1'b1);
    check("single_ov",    256'(out_valid_a),   256'(1));
    check("single_res0",  256'(res_a[15:0]),   256'(16'd24));
    check("single_res15", 256'(res_a[255:240]), 256'(16'd24));
    check("single_res_b", 256'(res_b[7:0]),    256'(8'd24));
    idle(1);

    // Multi-beat: 3 x 8 x 10 x (-1) = -240
    beat(10, 2'b11, 1'b0);
    beat(10, 2'b11, 1'b0);
    beat(10, 2'b11, 1'b1);
    check("multi_res_a", 256'(res_a[15:0]), 256'(16'hFF10));
`ifdef MM_TERNARY_SAT_EN
    check("multi_res_b", 256'(res_b[7:0]), 256'(8'h80));
`else
    check("multi_res_b", 256'(res_b[7:0]), 256'(8'h10));
`endif

    // Backpressure: buffer full and not draining stalls a pending beat
    out_ready = 1'b0;
    set_beat(5, 2'b01, 1'b1);
    repeat (5) begin
      step();
      check("stall_ready", 256'(in_ready_a),  256'(0));
      check("stall_ov",    256'(out_valid_a), 256'(1));
      check("stall_res",   256'(res_a[15:0]), 256'(16'hFF10));
    end
    out_ready = 1'b1;
    step();  // transfer and new close in the same cycle: 8 x 5 = 40
    check("xfer_close_ov",  256'(out_valid_a), 256'(1));
    check("xfer_close_res", 256'(res_a[15:0]), 256'(16'd40));
    idle(1);
    check("drained_ov", 256'(out_valid_a), 256'(0));
    #1;
    check("drained_ready", 256'(in_ready_a), 256'(1));

    // Forced close on dut_b after 4 beats without in_last: 4 x 8 = 32
    repeat (4) beat(1, 2'b01, 1'b0);
    check("forced_res_b", 256'(res_b[7:0]), 256'(8'd32));
    check("forced_err_b", 256'(err_b),      256'(1));
    check("forced_err_a", 256'(err_a),      256'(0));
    check("forced_ov_a",  256'(out_valid_a), 256'(0));
    beat(1, 2'b01, 1'b0);
    beat(1, 2'b01, 1'b1);
    check("six_beat_a",  256'(res_a[15:0]), 256'(16'd48));
    check("fresh_res_b", 256'(res_b[7:0]),  256'(8'd16));
    idle(1);

    // Zero-weight codes
    beat(7, 2'b10, 1'b1);
    check("zero_code", 256'(res_a[15:0]), 256'(16'd0));
    idle(1);

    // Reset mid-tile discards the partial sum
    beat(9, 2'b01, 1'b0);
    beat(9, 2'b01, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_err_b", 256'(err_b), 256'(0));
    beat(1, 2'b01, 1'b1);
    check("post_rst_a", 256'(res_a[15:0]), 256'(16'd8));
    check("post_rst_b", 256'(res_b[7:0]),  256'(8'd8));
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int w = 0; w < (DW*RN*LN)/32; w++) mat[w*32 +: 32] = $urandom();
      fil[31:0]  = $urandom();
      fil[63:32] = $urandom();
      in_valid   = ($urandom_range(0, 3) != 0);
      in_last    = ($urandom_range(0, 3) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
